// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs, stage enables/flushes,
// PC redirect, data-memory handshake and performance counters.
// master: the controller (drives enables/flushes/redirect/dmem_req/counters).
// slave : the pipeline datapath (drives hazard sources and dmem_ready).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_reg_dest;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_jump;
    logic [31:0]      mem_branch_tgt;
    logic [31:0]      mem_jump_tgt;
    logic             mem_read;
    logic             mem_write;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             pc_load;
    logic [31:0]      pc_target;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_dest,
        input  mem_branch, mem_zero, mem_jump, mem_branch_tgt, mem_jump_tgt,
        input  mem_read, mem_write, dmem_ready,
        output dmem_req, pc_en, pc_load, pc_target,
        output ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output mem_err, stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_dest,
        output mem_branch, mem_zero, mem_jump, mem_branch_tgt, mem_jump_tgt,
        output mem_read, mem_write, dmem_ready,
        input  dmem_req, pc_en, pc_load, pc_target,
        input  ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  mem_err, stall_cnt, flush_cnt, wait_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// MEM-stage branch/jump redirects and multi-cycle data-memory waits with timeout.
// Ports: clock, reset (sync, active-high); bus (pipe_hazard_ctrl_if.master)
// carrying hazard inputs, stage enables/flushes, PC redirect, dmem handshake,
// sticky mem_err and stall/flush/wait counters.
// Optional macro HAZ_PERF_CNT_EN enables the counters; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.master bus
);
    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       mem_err_q, mem_err_d;

    logic memop;
    logic taken;
    logic hz;
    logic stall_hit;
    logic flush_hit;
    logic in_wait;

    assign memop = bus.mem_read | bus.mem_write;
    assign taken = (bus.mem_branch & bus.mem_zero) | bus.mem_jump;
    assign hz    = bus.ex_mem_read & (bus.ex_reg_dest != 5'd0) &
                   ((bus.ex_reg_dest == bus.id_rs) |
                    (bus.id_uses_rt & (bus.ex_reg_dest == bus.id_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            wcnt_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        mem_err_d       = mem_err_q;
        stall_hit       = 1'b0;
        flush_hit       = 1'b0;
        in_wait         = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.pc_en       = 1'b1;
        bus.pc_load     = 1'b0;
        bus.pc_target   = bus.mem_jump_tgt;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.memwb_flush = 1'b0;

        if (reset) begin
            bus.pc_en       = 1'b0;
            bus.pc_target   = 32'd0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_en    = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
            bus.memwb_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    bus.dmem_req = memop;
                    if (memop && !bus.dmem_ready) begin
                        // Freeze IF..EX, push a bubble into WB.
                        bus.pc_en       = 1'b0;
                        bus.ifid_en     = 1'b0;
                        bus.idex_en     = 1'b0;
                        bus.exmem_en    = 1'b0;
                        bus.memwb_flush = 1'b1;
                        state_d         = MEM_WAIT;
                        wcnt_d          = 8'd1;
                    end else if (taken && !memop) begin
                        // A memop in MEM masks a (malformed) redirect.
                        flush_hit       = 1'b1;
                        bus.pc_load     = 1'b1;
                        bus.pc_target   = bus.mem_jump ? bus.mem_jump_tgt
                                                       : bus.mem_branch_tgt;
                        bus.ifid_flush  = 1'b1;
                        bus.idex_flush  = 1'b1;
                        bus.exmem_flush = 1'b1;
                    end else if (hz) begin
                        stall_hit      = 1'b1;
                        bus.pc_en      = 1'b0;
                        bus.ifid_en    = 1'b0;
                        bus.idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    in_wait      = 1'b1;
                    bus.dmem_req = 1'b1;
                    if (bus.dmem_ready || wcnt_q == TIMEOUT) begin
                        state_d = RUN;
                        wcnt_d  = 8'd0;
                        if (!bus.dmem_ready) begin
                            mem_err_d = 1'b1;
                        end
                    end else begin
                        bus.pc_en       = 1'b0;
                        bus.ifid_en     = 1'b0;
                        bus.idex_en     = 1'b0;
                        bus.exmem_en    = 1'b0;
                        bus.memwb_flush = 1'b1;
                        wcnt_d          = wcnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] wait_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            if (stall_hit && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (flush_hit && flush_q != CNT_MAX) begin
                flush_q <= flush_q + CNT_ONE;
            end
            if (in_wait && wait_q != CNT_MAX) begin
                wait_q <= wait_q + CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
    assign bus.wait_cnt  = wait_q;
`else
    logic unused_hits;
    assign unused_hits   = stall_hit ^ flush_hit ^ in_wait;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
    assign bus.wait_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): expected output
// vectors are queued per driven cycle and popped when the cycle is sampled.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 32;

    // {req,pc_en,pc_load,ifid_en,idex_en,exmem_en,memwb_en,
    //  ifid_fl,idex_fl,exmem_fl,memwb_fl,mem_err}
    localparam logic [11:0] RSTV   = 12'b0_0_0_0000_1111_0;
    localparam logic [11:0] RUNV   = 12'b0_1_0_1111_0000_0;
    localparam logic [11:0] LUV    = 12'b0_0_0_0111_0100_0;
    localparam logic [11:0] REDV   = 12'b0_1_1_1111_1110_0;
    localparam logic [11:0] MSTALL = 12'b1_0_0_0001_0001_0;
    localparam logic [11:0] MREL   = 12'b1_1_0_1111_0000_0;
    localparam logic [11:0] ERR    = 12'b0_0_0_0000_0000_1;
    localparam logic [31:0] JT     = 32'h0000_1234;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urt;
        logic        exrd;
        logic [4:0]  dest;
        logic        br;
        logic        z;
        logic        j;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        rd;
        logic        wr;
        logic        rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [43:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.urt = 1'b0;
        s.exrd = 1'b0; s.dest = 5'd0; s.br = 1'b0; s.z = 1'b0;
        s.j = 1'b0; s.bt = 32'h88; s.jt = JT;
        s.rd = 1'b0; s.wr = 1'b0; s.rdy = 1'b0;
        return s;
    endfunction

    function automatic logic [43:0] obs();
        return {bus.dmem_req, bus.pc_en, bus.pc_load, bus.ifid_en,
                bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush,
                bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.mem_err, bus.pc_target};
    endfunction

    task automatic apply(input stim_t s);
        rst                = s.rst;
        bus.id_rs          = s.rs;
        bus.id_rt          = s.rt;
        bus.id_uses_rt     = s.urt;
        bus.ex_mem_read    = s.exrd;
        bus.ex_reg_dest    = s.dest;
        bus.mem_branch     = s.br;
        bus.mem_zero       = s.z;
        bus.mem_jump       = s.j;
        bus.mem_branch_tgt = s.bt;
        bus.mem_jump_tgt   = s.jt;
        bus.mem_read       = s.rd;
        bus.mem_write      = s.wr;
        bus.dmem_ready     = s.rdy;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [43:0] got, e;
        for (int i = 0; i < 3; i++) begin
            s = idle();
            if (i < 2) begin
                s.rst = 1'b1; s.rs = 5'($urandom); s.rt = 5'($urandom);
                s.urt = 1'($urandom); s.exrd = 1'($urandom);
                s.dest = 5'($urandom); s.br = 1'($urandom);
                s.z = 1'($urandom); s.j = 1'($urandom);
                s.bt = $urandom; s.jt = $urandom; s.rd = 1'($urandom);
                s.wr = 1'($urandom); s.rdy = 1'($urandom);
            end
            apply(s);
            exp_q.push_back(i < 2 ? {RSTV, 32'h0} : {RUNV, JT});
            @(negedge clk);
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %h exp %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        logic [43:0] e[6];
        logic [43:0] got, x;
        foreach (s[i]) s[i] = idle();
        s[0].exrd = 1; s[0].dest = 5; s[0].rs = 5;           e[0] = {LUV, JT};
                                                              e[1] = {RUNV, JT};
        s[2].exrd = 1; s[2].dest = 0; s[2].rs = 0;           e[2] = {RUNV, JT};
        s[3].exrd = 1; s[3].dest = 5; s[3].rs = 3; s[3].rt = 5;
                                                              e[3] = {RUNV, JT};
        s[4] = s[3]; s[4].urt = 1;                            e[4] = {LUV, JT};
                                                              e[5] = {RUNV, JT};
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs();
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL load_use[%0d]: got %h exp %h", i, got, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        stim_t s[5];
        logic [43:0] e[5];
        logic [43:0] got, x;
        foreach (s[i]) s[i] = idle();
        s[0].br = 1; s[0].z = 1; s[0].bt = 32'h40;
        s[0].exrd = 1; s[0].dest = 5; s[0].rs = 5;     e[0] = {REDV, 32'h40};
        s[1].br = 1; s[1].z = 0;                       e[1] = {RUNV, JT};
        s[2].br = 1; s[2].z = 1; s[2].bt = 32'h40;
        s[2].j = 1; s[2].jt = 32'h100;                 e[2] = {REDV, 32'h100};
        s[3].br = 1; s[3].z = 1; s[3].rd = 1; s[3].rdy = 1;
                                                       e[3] = {MREL, JT};
                                                       e[4] = {RUNV, JT};
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs();
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL redirect[%0d]: got %h exp %h", i, got, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[5];
        logic [43:0] e[5];
        logic [43:0] got, x;
        foreach (s[i]) s[i] = idle();
        for (int i = 0; i < 4; i++) s[i].rd = 1;
        s[1].br = 1; s[1].z = 1;
        s[3].rdy = 1;
        e[0] = {MSTALL, JT}; e[1] = {MSTALL, JT}; e[2] = {MSTALL, JT};
        e[3] = {MREL, JT};   e[4] = {RUNV, JT};
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs();
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %h exp %h", i, got, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s[7];
        logic [43:0] e[7];
        logic [43:0] got, x;
        foreach (s[i]) s[i] = idle();
        for (int i = 0; i < 5; i++) begin
            s[i].wr = 1;
            e[i] = {MSTALL, JT};
        end
        e[4] = {MREL, JT};
        e[5] = {RUNV | ERR, JT};
        e[6] = {RUNV | ERR, JT};
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs();
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL timeout[%0d]: got %h exp %h", i, got, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] es, ef, ew;
`ifdef HAZ_PERF_CNT_EN
        es = 2; ef = 2; ew = 7;
`else
        es = 0; ef = 0; ew = 0;
`endif
        apply(idle());
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== es) begin
            errors++;
            $display("FAIL stall_cnt: got %0d exp %0d", bus.stall_cnt, es);
        end
        checks++;
        if (bus.flush_cnt !== ef) begin
            errors++;
            $display("FAIL flush_cnt: got %0d exp %0d", bus.flush_cnt, ef);
        end
        checks++;
        if (bus.wait_cnt !== ew) begin
            errors++;
            $display("FAIL wait_cnt: got %0d exp %0d", bus.wait_cnt, ew);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        stim_t s[4];
        logic [43:0] e[4];
        logic [43:0] got, x;
        foreach (s[i]) s[i] = idle();
        s[0].rd = 1; s[1].rd = 1; s[2].rd = 1; s[2].rst = 1;
        e[0] = {MSTALL | ERR, JT};
        e[1] = {MSTALL | ERR, JT};
        e[2] = {RSTV | ERR, 32'h0};
        e[3] = {RUNV, JT};
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs();
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL rst_mid_wait[%0d]: got %h exp %h", i, got, x);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== '0) begin
            errors++;
            $display("FAIL cnt_after_rst: got %0d/%0d/%0d exp 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_counters();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined processor.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC register.
- Resolves three hazards:
  - load-use hazards (ID vs EX);
  - control redirects for branches and jumps resolved in MEM;
  - multi-cycle data-memory accesses via a req/ready handshake with a timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before forced release; legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_dest  in  5  EX destination register.
- mem_branch  in  1  MEM instruction is a branch.
- mem_zero  in  1  ALU zero flag of the MEM instruction.
- mem_jump  in  1  MEM instruction is a jump.
- mem_branch_tgt  in  32  branch target.
- mem_jump_tgt  in  32  jump target.
- mem_read  in  1  MEM instruction reads data memory.
- mem_write  in  1  MEM instruction writes data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_en  out  1  PC register enable.
- pc_load  out  1  select pc_target as the next PC.
- pc_target  out  32  redirect address.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM register enable.
- memwb_en  out  1  MEM/WB register enable.
- ifid_flush  out  1  zero IF/ID contents at the next edge.
- idex_flush  out  1  zero ID/EX contents at the next edge.
- exmem_flush  out  1  zero EX/MEM contents at the next edge.
- memwb_flush  out  1  zero MEM/WB contents at the next edge.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirects taken.
- wait_cnt  out  CNT_W  MEM_WAIT cycles.

Behaviour:
- Structure:
  - Registered state: FSM {RUN, MEM_WAIT}, 8-bit wait counter wcnt, mem_err, and the performance counters.
  - All other outputs are combinational from the state and current inputs.
- Reset (sync, while asserted):
  - State RUN, wcnt=0, mem_err=0, counters=0.
  - Outputs forced to: all *_en=0, all *_flush=1, dmem_req=0, pc_load=0, pc_target=0.
- Default in RUN: all *_en=1, all *_flush=0, pc_load=0, pc_target=mem_jump_tgt.
- Memory access:
  - memop = mem_read|mem_write.
  - In RUN, dmem_req=memop.
  - memop and dmem_ready in the same cycle: normal advance, 0 extra cycles.
  - memop and !dmem_ready:
    - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush=1 (bubble into WB).
    - Next state MEM_WAIT, wcnt<=1.
- MEM_WAIT:
  - dmem_req=1 held.
  - Stall outputs as above every cycle until release.
  - Release on dmem_ready: all *_en=1, no flushes, next state RUN, wcnt<=0.
  - Timeout: if wcnt==MEM_TIMEOUT and !dmem_ready, release identically and set mem_err<=1.
  - Otherwise wcnt<=wcnt+1.
  - Total stall = wait cycles; the access completes on the release cycle.
- Redirect (RUN only):
  - taken = (mem_branch & mem_zero) | mem_jump.
  - Asserts pc_load=1 and ifid_flush=idex_flush=exmem_flush=1; enables stay 1.
  - pc_target = mem_jump ? mem_jump_tgt : mem_branch_tgt (jump has priority).
  - Branch penalty is 3 cycles.
- Load-use (RUN only):
  - hz = ex_mem_read & (ex_reg_dest!=0) & (ex_reg_dest==id_rs | (id_uses_rt & ex_reg_dest==id_rt)).
  - Asserts pc_en=0, ifid_en=0, idex_flush=1.
  - Exactly 1 stall cycle; hz clears naturally as the load moves to MEM.
- Priority, highest first:
  1. Reset.
  2. Memory stall (memop & !ready, or MEM_WAIT not releasing).
  3. Redirect.
  4. Load-use.
- Simultaneous events:
  - Redirect plus load-use: redirect wins and hz is ignored; the ID instruction is killed.
  - The branch/jump and memop cannot both be true in one MEM instruction. If both appear, memop wins.
- Reset mid-MEM_WAIT: return to RUN next cycle, dmem_req drops, mem_err cleared.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - stall_cnt +1 per cycle hz stalls.
  - flush_cnt +1 per taken redirect.
  - wait_cnt +1 per cycle in MEM_WAIT.
  - All saturate at 2^CNT_W-1 and reset to 0.
- When undefined: the ports remain and are tied to 0, with no counter flops.

Test Plan:
- Reset asserted 2 cycles with random inputs -> all *_en=0, all flushes=1, dmem_req=0. After release with no hazards -> all *_en=1, flushes=0.
- ex_mem_read=1, ex_reg_dest=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Repeat with ex_reg_dest=0 -> no stall. Repeat with id_rt=5, id_uses_rt=0 -> no stall.
- mem_branch=1, mem_zero=1, mem_branch_tgt=0x40, with load-use also true -> pc_load=1, pc_target=0x40, ifid/idex/exmem_flush=1, pc_en=1. Jump with mem_jump_tgt=0x100 -> pc_target=0x100.
- mem_read=1, dmem_ready low 3 cycles then high -> dmem_req=1 throughout. 3 stall cycles with memwb_flush=1, then a release cycle with all enables 1, then RUN. wait_cnt=3 when HAZ_PERF_CNT_EN is defined.
- mem_write=1, dmem_ready never asserted, MEM_TIMEOUT=4 -> release on the 5th cycle after entry (wcnt==4), mem_err=1 sticky until reset.
- Reset asserted during MEM_WAIT -> next cycle state RUN, dmem_req=0, mem_err=0, counters=0.
